// File: rtl/tt_pkg.sv
// Shared types and constants for the times-table sequencer and its operand counter.
package tt_pkg;

  // Default operand and product widths for the 8x8 times table.
  localparam int OPW_DEF  = 3;
  localparam int RESW_DEF = 2 * OPW_DEF;

  // Largest operand value; a run ends when a (and b in full mode) reaches it.
  localparam int OP_MAX = 7;

  // Run modes, sampled when a run starts.
  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_FULL   = 1'b1;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUTPUT,
    DONE
  } state_e;

endpackage

// File: rtl/tt_operand_gen.sv
// Operand pair counter: walks a = 0..OP_MAX for one table, or the whole
// table in b-major order, and flags the final pair of the run.
module tt_operand_gen
  import tt_pkg::*;
#(
  parameter int OPW = OPW_DEF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           load_i,
  input  logic           advance_i,
  input  logic           mode_i,
  input  logic [OPW-1:0] table_sel_i,
  output logic [OPW-1:0] a_o,
  output logic [OPW-1:0] b_o,
  output logic           is_last_o
);

  localparam logic [OPW-1:0] A_TOP = OPW'(OP_MAX);

  logic [OPW-1:0] a_q, a_d;
  logic [OPW-1:0] b_q, b_d;
  logic           mode_q, mode_d;

  // Next operand pair: load restarts the walk, advance steps a and carries into b in full mode.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    mode_d = mode_q;
    if (load_i) begin
      a_d    = '0;
      b_d    = (mode_i == MODE_FULL) ? '0 : table_sel_i;
      mode_d = mode_i;
    end else if (advance_i) begin
      if (a_q == A_TOP) begin
        a_d = '0;
        if (mode_q == MODE_FULL) begin
          b_d = b_q + OPW'(1);
        end
      end else begin
        a_d = a_q + OPW'(1);
      end
    end
  end

  // Operand registers; the latched mode decides whether b carries.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= MODE_SINGLE;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      mode_q <= mode_d;
    end
  end

  assign a_o       = a_q;
  assign b_o       = b_q;
  assign is_last_o = (a_q == A_TOP) && ((mode_q == MODE_SINGLE) || (b_q == A_TOP));

endmodule

// File: rtl/times_table_sequencer.sv
// Times-table sequencer: feeds operand pairs to a registered multiplier,
// waits out its latency, presents {a, b, product} on a valid/ready stream
// and keeps a sticky flag if any product disagrees with a local a*b.
module times_table_sequencer
  import tt_pkg::*;
#(
  parameter int OPW     = OPW_DEF,
  parameter int RESW    = RESW_DEF,
  parameter int MUL_LAT = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            mode_i,
  input  logic [OPW-1:0]  table_sel_i,
  input  logic            abort_i,
  output logic [OPW-1:0]  mul_a_o,
  output logic [OPW-1:0]  mul_b_o,
  output logic            mul_en_o,
  input  logic [RESW-1:0] mul_result_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [OPW-1:0]  out_a_o,
  output logic [OPW-1:0]  out_b_o,
  output logic [RESW-1:0] out_prod_o,
  output logic            out_last_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            mismatch_o
);

  // Wide enough to hold MUL_LAT-1; a one-cycle multiplier still gets a 1-bit counter.
  localparam int CNTW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_e            state_q;
  logic [CNTW-1:0]   cnt_q;
  logic              mul_en_q;
  logic              out_valid_q;
  logic [OPW-1:0]    out_a_q;
  logic [OPW-1:0]    out_b_q;
  logic [RESW-1:0]   out_prod_q;
  logic              out_last_q;
  logic              busy_q;
  logic              done_q;
  logic              mismatch_q;

  logic [OPW-1:0]    op_a;
  logic [OPW-1:0]    op_b;
  logic              op_last;
  logic              op_load;
  logic              op_advance;
  logic              run_active;
  logic [RESW-1:0]   ref_prod;

  // ISSUE, WAIT and OUTPUT are the states an abort can cut short.
  assign run_active = (state_q == ISSUE) || (state_q == WAIT) || (state_q == OUTPUT);

  // The counter restarts on an accepted start and steps after every
  // consumed beat that is not the last; an abort freezes it where it is.
  assign op_load    = (state_q == IDLE) && start_i;
  assign op_advance = (state_q == OUTPUT) && out_ready_i && !out_last_q && !abort_i;

  // Full-width reference product, compared against what the multiplier returned.
  assign ref_prod = RESW'(op_a) * RESW'(op_b);

  tt_operand_gen #(
    .OPW(OPW)
  ) u_operand_gen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (op_load),
    .advance_i  (op_advance),
    .mode_i     (mode_i),
    .table_sel_i(table_sel_i),
    .a_o        (op_a),
    .b_o        (op_b),
    .is_last_o  (op_last)
  );

  // Sequencer FSM with all stream, multiplier-control and status outputs registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mul_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_prod_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i && run_active) begin
        state_q     <= IDLE;
        mul_en_q    <= 1'b0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              mismatch_q <= 1'b0;
              mul_en_q   <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= ISSUE;
            end
          end
          ISSUE: begin
            mul_en_q <= 1'b0;
            cnt_q    <= CNTW'(MUL_LAT - 1);
            state_q  <= WAIT;
          end
          WAIT: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - CNTW'(1);
            end else begin
              out_prod_q  <= mul_result_i;
              out_a_q     <= op_a;
              out_b_q     <= op_b;
              out_valid_q <= 1'b1;
              out_last_q  <= op_last;
              if (mul_result_i != ref_prod) begin
                mismatch_q <= 1'b1;
              end
              state_q <= OUTPUT;
            end
          end
          OUTPUT: begin
            if (out_ready_i) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              if (out_last_q) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                mul_en_q <= 1'b1;
                state_q  <= ISSUE;
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign mul_a_o     = op_a;
  assign mul_b_o     = op_b;
  assign mul_en_o    = mul_en_q;
  assign out_valid_o = out_valid_q;
  assign out_a_o     = out_a_q;
  assign out_b_o     = out_b_q;
  assign out_prod_o  = out_prod_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign mismatch_o  = mismatch_q;

endmodule
